// File: rtl/regfile_write_buffer.sv
// Write-back FIFO in front of the 32x32 register file. It drains one entry per cycle
// and gives two operand ports a bypass view of writes still queued.
module regfile_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       InAddr,
  input  logic [31:0]      InData,
  input  logic             DrainEnable,
  output logic [4:0]       WriteRegister,
  output logic [31:0]      WriteData,
  output logic             RegWrite,
  input  logic [4:0]       LookupAddr1,
  input  logic [4:0]       LookupAddr2,
  output logic             Hit1,
  output logic             Hit2,
  output logic [31:0]      HitData1,
  output logic [31:0]      HitData2,
  output logic [PTR_W:0]   Count,
  output logic             Empty,
  output logic             Full
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              accept;
  logic              push;
  logic              pop;

  // Handshake status depends only on registered occupancy.
  assign Empty   = (Count == '0);
  assign Full    = (Count == FULL_COUNT);
  assign InReady = !Full;
  assign accept  = InValid && InReady;
  // Writes to r0 complete the handshake but are dropped.
  assign push    = accept && (InAddr != '0);
  assign pop     = RegWrite;

  // Head entry drives the regfile write port.
  always_comb begin
    RegWrite      = !Empty && DrainEnable;
    WriteRegister = '0;
    WriteData     = '0;
    if (!Empty) begin
      WriteRegister = addr_q[rd_ptr];
      WriteData     = data_q[rd_ptr];
    end
  end

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  // Payload storage is left uninitialised on reset; valid bits gate its use.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[wr_ptr] <= InAddr;
      data_q[wr_ptr] <= InData;
    end
  end

  // Scan oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    Hit1     = 1'b0;
    Hit2     = 1'b0;
    HitData1 = '0;
    HitData2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (valid_q[idx] && (LookupAddr1 != '0) && (addr_q[idx] == LookupAddr1)) begin
        Hit1     = 1'b1;
        HitData1 = data_q[idx];
      end
      if (valid_q[idx] && (LookupAddr2 != '0) && (addr_q[idx] == LookupAddr2)) begin
        Hit2     = 1'b1;
        HitData2 = data_q[idx];
      end
    end
  end

endmodule
